// File: rtl/memory_interface_pkg.sv
// Shared types and defaults for the memory_interface block.
//   state_t    : control FSM states
//   op_t       : latched operation encoding (read / write / illegal)
//   decode_op  : classifies a sampled request into an op_t
//   DEF_*      : default parameter values for the top level
package memory_interface_pkg;

    localparam int unsigned DEF_DATAWIDTH_BUS      = 32;
    localparam int unsigned DEF_DATAWIDTH_MEM_ADDR = 10;
    localparam int unsigned DEF_WAIT_STATES        = 2;

    // Wait-state counter covers the legal range 0..15.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_ACK,
        ST_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_ILLEGAL
    } op_t;

    // Both request lines high, or a rejected address, is an illegal access.
    function automatic op_t decode_op(input logic rd, input logic wr, input logic misaligned);
        if ((rd && wr) || misaligned) begin
            return OP_ILLEGAL;
        end else if (wr) begin
            return OP_WRITE;
        end else begin
            return OP_READ;
        end
    endfunction

endpackage

// File: rtl/memory_interface_ram.sv
// Single-port synchronous RAM with one write enable and a registered read port.
// Contents are deliberately not reset.
//   clk   : clock, rising edge
//   en    : port enable (read or write this cycle)
//   we    : write enable, qualified by en
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, updated only on enabled reads
module memory_interface_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage port: write-or-read, never both in one cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/memory_interface.sv
// Request/acknowledge memory interface between a control unit and a word RAM.
// A request level (RD or WRMain) is sampled in IDLE, WAIT_STATES wait cycles
// are inserted, a single-cycle RAM access is made, and ACK pulses one cycle
// WAIT_STATES+2 cycles after the sampling edge. The FSM then waits for both
// request lines to drop before accepting a new request.
// Optional feature: define MEMORY_INTERFACE_ALIGN_CHECK_EN to reject byte
// addresses with A[1:0] != 0 as illegal accesses.
// Ports:
//   MEMORY_INTERFACE_CLOCK_50      : clock, rising edge
//   MEMORY_INTERFACE_ResetInLow_In : asynchronous active-low reset
//   MEMORY_INTERFACE_A_InBus       : byte address
//   MEMORY_INTERFACE_B_InBus       : write data
//   MEMORY_INTERFACE_RD_In         : read request level
//   MEMORY_INTERFACE_WRMain_In     : write request level
//   MEMORY_INTERFACE_ACK_Out       : one-cycle completion pulse
//   MEMORY_INTERFACE_Data_OutBus   : registered read data (held between reads)
//   MEMORY_INTERFACE_Error_Out     : one-cycle illegal-access pulse, with ACK
module memory_interface
    import memory_interface_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS      = DEF_DATAWIDTH_BUS,
    parameter int unsigned DATAWIDTH_MEM_ADDR = DEF_DATAWIDTH_MEM_ADDR,
    parameter int unsigned WAIT_STATES        = DEF_WAIT_STATES
) (
    input  logic                     MEMORY_INTERFACE_CLOCK_50,
    input  logic                     MEMORY_INTERFACE_ResetInLow_In,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_INTERFACE_A_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_INTERFACE_B_InBus,
    input  logic                     MEMORY_INTERFACE_RD_In,
    input  logic                     MEMORY_INTERFACE_WRMain_In,
    output logic                     MEMORY_INTERFACE_ACK_Out,
    output logic [DATAWIDTH_BUS-1:0] MEMORY_INTERFACE_Data_OutBus,
    output logic                     MEMORY_INTERFACE_Error_Out
);

    localparam int unsigned DW = DATAWIDTH_BUS;
    localparam int unsigned AW = DATAWIDTH_MEM_ADDR;

    logic clk;
    logic rst_n;
    assign clk   = MEMORY_INTERFACE_CLOCK_50;
    assign rst_n = MEMORY_INTERFACE_ResetInLow_In;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    op_t              op_q;
    logic             ack_q;
    logic             err_q;
    logic [DW-1:0]    dout_q;

    logic             req_c;
    logic             misaligned_c;
    op_t              req_op_c;
    logic             ram_en_c;
    logic             ram_we_c;
    logic [DW-1:0]    ram_rdata;

    assign req_c = MEMORY_INTERFACE_RD_In | MEMORY_INTERFACE_WRMain_In;

`ifdef MEMORY_INTERFACE_ALIGN_CHECK_EN
    assign misaligned_c = |MEMORY_INTERFACE_A_InBus[1:0];
`else
    assign misaligned_c = 1'b0;
`endif

    assign req_op_c = decode_op(MEMORY_INTERFACE_RD_In, MEMORY_INTERFACE_WRMain_In, misaligned_c);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Leave on the edge where the counter reads 1.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS:  state_d = ST_ACK;
            ST_ACK:     state_d = ST_RELEASE;
            ST_RELEASE: begin
                if (!req_c) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Request latch, wait counter and registered outputs. ACK/Error are
    // registered off the ACK state so they appear WAIT_STATES+2 cycles after
    // sampling, together with the RAM's registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OP_READ;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            ack_q <= (state_q == ST_ACK);
            err_q <= (state_q == ST_ACK) && (op_q == OP_ILLEGAL);
            if ((state_q == ST_ACK) && (op_q == OP_READ)) begin
                dout_q <= ram_rdata;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_c) begin
                        cnt_q   <= CNT_W'(WAIT_STATES);
                        addr_q  <= MEMORY_INTERFACE_A_InBus[AW+1:2];
                        wdata_q <= MEMORY_INTERFACE_B_InBus;
                        op_q    <= req_op_c;
                    end
                end
                ST_WAIT: cnt_q <= cnt_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Illegal accesses never touch the RAM.
    assign ram_en_c = (state_q == ST_ACCESS) && (op_q != OP_ILLEGAL);
    assign ram_we_c = (op_q == OP_WRITE);

    memory_interface_ram #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (ram_we_c),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign MEMORY_INTERFACE_ACK_Out     = ack_q;
    assign MEMORY_INTERFACE_Error_Out   = err_q;
    assign MEMORY_INTERFACE_Data_OutBus = dout_q;

endmodule
